// File: rtl/regfile_seq_ctrl_pkg.sv
// Shared definitions for the register-file instruction sequencer.
// Holds the default data/address widths, the 3-bit opcode encoding and the
// four-state sequencer encoding used by the controller and its ALU.
package regfile_seq_ctrl_pkg;

   localparam int DEF_DATA_W = 4;
   localparam int DEF_ADDR_W = 2;

   typedef enum logic [2:0] {
      OP_NOP = 3'b000,
      OP_LDI = 3'b001,
      OP_MOV = 3'b010,
      OP_ADD = 3'b011,
      OP_SUB = 3'b100,
      OP_AND = 3'b101,
      OP_OR  = 3'b110,
      OP_XOR = 3'b111
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_READ = 2'b01,
      ST_EXEC = 2'b10,
      ST_WB   = 2'b11
   } state_e;

endpackage

// File: rtl/regfile_seq_ctrl_if.sv
// Instruction handshake bundle between an instruction source and the
// sequencer.
//   INST_VALID  source -> sequencer  instruction fields are valid
//   INST_READY  sequencer -> source  sequencer can accept an instruction
//   OPCODE      3-bit operation
//   DST/SRCA/SRCB register addresses (ADDR_W)
//   IMM         immediate operand for LDI (DATA_W)
// master = instruction source, slave = sequencer.
interface regfile_seq_ctrl_if
   import regfile_seq_ctrl_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
);

   logic              INST_VALID;
   logic              INST_READY;
   logic [2:0]        OPCODE;
   logic [ADDR_W-1:0] DST;
   logic [ADDR_W-1:0] SRCA;
   logic [ADDR_W-1:0] SRCB;
   logic [DATA_W-1:0] IMM;

   modport master (
      output INST_VALID, OPCODE, DST, SRCA, SRCB, IMM,
      input  INST_READY
   );

   modport slave (
      input  INST_VALID, OPCODE, DST, SRCA, SRCB, IMM,
      output INST_READY
   );

endinterface

// File: rtl/regfile_seq_ctrl_seq_alu.sv
// Combinational ALU for the sequencer.
//   op     opcode (see regfile_seq_ctrl_pkg)
//   a, b   captured register operands
//   imm    latched immediate (LDI)
//   result DATA_W-bit result, wraps modulo 2^DATA_W
//   carry  ADD carry-out, SUB borrow (a < b), otherwise 0
module seq_alu
   import regfile_seq_ctrl_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] imm,
   output logic [DATA_W-1:0] result,
   output logic              carry
);

   logic [DATA_W:0] sum;

   assign sum = {1'b0, a} + {1'b0, b};

   // NOP produces zero; its result is never written back.
   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (opcode_e'(op))
         OP_LDI: result = imm;
         OP_MOV: result = a;
         OP_ADD: {carry, result} = sum;
         OP_SUB: begin
            result = a - b;
            carry  = (a < b);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         default: begin
            result = '0;
            carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/regfile_seq_ctrl.sv
// Multi-cycle instruction sequencer in front of a small register file.
// Accepts one instruction per handshake, reads both operands, executes in
// seq_alu and writes the result back, pulsing DONE on retirement.
//   CLK, RST         clock and synchronous active-high reset
//   inst             instruction handshake (slave side)
//   Aaddr/Baddr      register file read addresses
//   Adata/Bdata      register file read data (combinational)
//   WR/Daddr/Ddata   register file write port
//   DONE             one-cycle retirement pulse
//   BUSY             high outside IDLE
//   ZERO/CARRY       flags of the last written result
module regfile_seq_ctrl
   import regfile_seq_ctrl_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              CLK,
   input  logic              RST,
   regfile_seq_ctrl_if.slave inst,
   output logic [ADDR_W-1:0] Aaddr,
   output logic [ADDR_W-1:0] Baddr,
   input  logic [DATA_W-1:0] Adata,
   input  logic [DATA_W-1:0] Bdata,
   output logic              WR,
   output logic [ADDR_W-1:0] Daddr,
   output logic [DATA_W-1:0] Ddata,
   output logic              DONE,
   output logic              BUSY,
   output logic              ZERO,
   output logic              CARRY
);

   state_e            state;
   logic [2:0]        op_q;
   logic [DATA_W-1:0] imm_q;
   logic [DATA_W-1:0] opa_q;
   logic [DATA_W-1:0] opb_q;
   logic              res_carry_q;
   logic [DATA_W-1:0] alu_result;
   logic              alu_carry;

   seq_alu #(.DATA_W(DATA_W)) alu (
      .op     (op_q),
      .a      (opa_q),
      .b      (opb_q),
      .imm    (imm_q),
      .result (alu_result),
      .carry  (alu_carry)
   );

   // Sequencer. Handshake/status outputs are registered alongside the state
   // so they always match it. Ddata is the result register itself, and
   // Aaddr/Baddr/Daddr are loaded at accept so they hold until the next one.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state           <= ST_IDLE;
         inst.INST_READY <= 1'b1;
         BUSY            <= 1'b0;
         WR              <= 1'b0;
         DONE            <= 1'b0;
         Aaddr           <= '0;
         Baddr           <= '0;
         Daddr           <= '0;
         Ddata           <= '0;
         ZERO            <= 1'b0;
         CARRY           <= 1'b0;
         op_q            <= OP_NOP;
         imm_q           <= '0;
         opa_q           <= '0;
         opb_q           <= '0;
         res_carry_q     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (inst.INST_VALID) begin
                  op_q            <= inst.OPCODE;
                  imm_q           <= inst.IMM;
                  Aaddr           <= inst.SRCA;
                  Baddr           <= inst.SRCB;
                  Daddr           <= inst.DST;
                  inst.INST_READY <= 1'b0;
                  BUSY            <= 1'b1;
                  state           <= ST_READ;
               end
            end
            ST_READ: begin
               opa_q <= Adata;
               opb_q <= Bdata;
               state <= ST_EXEC;
            end
            ST_EXEC: begin
               Ddata       <= alu_result;
               res_carry_q <= alu_carry;
               WR          <= (op_q != OP_NOP);
               DONE        <= 1'b1;
               state       <= ST_WB;
            end
            ST_WB: begin
               // Flags only follow results that are actually written.
               if (WR) begin
                  ZERO  <= (Ddata == '0);
                  CARRY <= res_carry_q;
               end
               WR              <= 1'b0;
               DONE            <= 1'b0;
               BUSY            <= 1'b0;
               inst.INST_READY <= 1'b1;
               state           <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Self-checking bench for regfile_seq_ctrl with a behavioural register file.
// The driver computes each instruction's outcome from a plain array model
// and queues it; the monitor checks every DONE against the queue.
module tb_regfile_seq_ctrl;
   import regfile_seq_ctrl_pkg::*;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   always #5 CLK = ~CLK;

   regfile_seq_ctrl_if bus ();

   logic [DEF_ADDR_W-1:0] Aaddr, Baddr, Daddr;
   logic [DEF_DATA_W-1:0] Adata, Bdata, Ddata;
   logic WR, DONE, BUSY, ZERO, CARRY;

   regfile_seq_ctrl dut (
      .CLK   (CLK),
      .RST   (RST),
      .inst  (bus.slave),
      .Aaddr (Aaddr),
      .Baddr (Baddr),
      .Adata (Adata),
      .Bdata (Bdata),
      .WR    (WR),
      .Daddr (Daddr),
      .Ddata (Ddata),
      .DONE  (DONE),
      .BUSY  (BUSY),
      .ZERO  (ZERO),
      .CARRY (CARRY)
   );

   // Register file: combinational reads, write on the rising edge.
   logic [DEF_DATA_W-1:0] rf [4];

   always_ff @(posedge CLK) begin
      if (WR) rf[Daddr] <= Ddata;
   end

   assign Adata = rf[Aaddr];
   assign Bdata = rf[Baddr];

   int cyc = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      bit       wr;
      int       dst;
      int       data;
      bit       zero;
      bit       carry;
      int       regval;
      int       acc;
   } exp_t;

   exp_t sb [$];

   int checks = 0;
   int errors = 0;
   int mreg [4] = '{0, 0, 0, 0};
   bit mzero = 0;
   bit mcarry = 0;
   int lastAcc = -100;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference outcome of one instruction from the register and flag model.
   task automatic modelInstr(input int op, input int dst, input int sa, input int sb_,
                             input int imm, input int acc);
      int a, b, r, c;
      exp_t e;
      a = mreg[sa];
      b = mreg[sb_];
      r = 0;
      c = 0;
      case (op)
         1: r = imm;
         2: r = a;
         3: begin r = (a + b) % 16; c = ((a + b) > 15) ? 1 : 0; end
         4: begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
         5: r = a & b;
         6: r = a | b;
         7: r = a ^ b;
         default: r = 0;
      endcase
      e.wr = (op != 0);
      if (e.wr) begin
         mreg[dst] = r;
         mzero = (r == 0);
         mcarry = (c != 0);
      end
      e.dst = dst;
      e.data = r;
      e.zero = mzero;
      e.carry = mcarry;
      e.regval = mreg[dst];
      e.acc = acc;
      sb.push_back(e);
   endtask

   // Present one instruction and hold it until accepted. With hold=1 VALID
   // stays high afterwards so the next call queues up behind it.
   task automatic applyStimulus(input int op, input int dst, input int sa, input int sb_,
                                input int imm, input bit hold, input bit checkGap);
      bit accepted = 0;
      @(negedge CLK);
      bus.INST_VALID = 1'b1;
      bus.OPCODE = op[2:0];
      bus.DST = dst[1:0];
      bus.SRCA = sa[1:0];
      bus.SRCB = sb_[1:0];
      bus.IMM = imm[3:0];
      for (int i = 0; i < 20 && !accepted; i++) begin
         if (bus.INST_READY) begin
            accepted = 1;
            if (checkGap) checkOutput("accept_interval", cyc - lastAcc, 4);
            lastAcc = cyc;
            modelInstr(op, dst, sa, sb_, imm, cyc);
            @(posedge CLK);
            #1;
         end else begin
            @(negedge CLK);
         end
      end
      if (!accepted) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: INST_READY stayed 0, expected 1");
      end
      if (!hold) bus.INST_VALID = 1'b0;
   endtask

   // Monitor: every DONE must match the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (WR) checkOutput("wr_implies_done", DONE, 1);
         if (DONE) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_done: DONE=1 with no instruction pending, expected 0");
            end else begin
               e = sb.pop_front();
               checkOutput("wr", WR, e.wr);
               if (e.wr) begin
                  checkOutput("daddr", Daddr, e.dst);
                  checkOutput("ddata", Ddata, e.data);
               end
               checkOutput("latency", cyc - e.acc, 3);
               @(negedge CLK);
               checkOutput("done_pulse", DONE, 0);
               checkOutput("zero", ZERO, e.zero);
               checkOutput("carry", CARRY, e.carry);
               checkOutput("regval", rf[e.dst], e.regval);
            end
         end
      end
   end

   task automatic waitDrain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLK);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: %0d pending, expected 0", sb.size());
      end
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      int op, d, a, b, im;
      bus.INST_VALID = 1'b0;
      bus.OPCODE = 3'd0;
      bus.DST = 2'd0;
      bus.SRCA = 2'd0;
      bus.SRCB = 2'd0;
      bus.IMM = 4'd0;

      repeat (2) @(negedge CLK);
      checkOutput("rst_ready", bus.INST_READY, 1);
      checkOutput("rst_busy", BUSY, 0);
      checkOutput("rst_wr", WR, 0);
      checkOutput("rst_done", DONE, 0);
      checkOutput("rst_zero", ZERO, 0);
      checkOutput("rst_carry", CARRY, 0);
      RST = 1'b0;

      for (int r = 0; r < 4; r++) applyStimulus(1, r, 0, 0, 0, 0, 0);
      waitDrain();

      // LDI/LDI/ADD: R3 = 8, no carry
      applyStimulus(1, 1, 0, 0, 5, 0, 0);
      applyStimulus(1, 2, 0, 0, 3, 0, 0);
      applyStimulus(3, 3, 1, 2, 0, 0, 0);
      waitDrain();

      // 9+9 carries; 9-9 sets ZERO
      applyStimulus(1, 0, 0, 0, 9, 0, 0);
      applyStimulus(1, 1, 0, 0, 9, 0, 0);
      applyStimulus(3, 2, 0, 1, 0, 0, 0);
      applyStimulus(4, 3, 0, 1, 0, 0, 0);
      // NOP after ZERO=1 keeps flags and registers
      applyStimulus(0, 3, 0, 1, 0, 0, 0);
      waitDrain();

      // Borrow, then logic ops on C and A
      applyStimulus(1, 0, 0, 0, 2, 0, 0);
      applyStimulus(1, 1, 0, 0, 5, 0, 0);
      applyStimulus(4, 2, 0, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 12, 0, 0);
      applyStimulus(1, 1, 0, 0, 10, 0, 0);
      applyStimulus(5, 2, 0, 1, 0, 0, 0);
      applyStimulus(6, 2, 0, 1, 0, 0, 0);
      applyStimulus(7, 3, 0, 1, 0, 0, 0);
      waitDrain();

      // VALID held high: four queued instructions, dependent doubling
      applyStimulus(1, 1, 0, 0, 1, 1, 0);
      applyStimulus(3, 1, 1, 1, 0, 1, 1);
      applyStimulus(3, 1, 1, 1, 0, 1, 1);
      applyStimulus(3, 1, 1, 1, 0, 0, 1);
      waitDrain();

      // Reset during EXEC of LDI R2,#7 with R2 = 4: nothing is written
      applyStimulus(1, 2, 0, 0, 4, 0, 0);
      waitDrain();
      @(negedge CLK);
      bus.INST_VALID = 1'b1;
      bus.OPCODE = 3'd1;
      bus.DST = 2'd2;
      bus.IMM = 4'd7;
      for (int i = 0; i < 20 && !bus.INST_READY; i++) @(negedge CLK);
      @(posedge CLK);
      #1 bus.INST_VALID = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      mzero = 0;
      mcarry = 0;
      checkOutput("abort_ready", bus.INST_READY, 1);
      checkOutput("abort_busy", BUSY, 0);
      checkOutput("abort_wr", WR, 0);
      checkOutput("abort_done", DONE, 0);
      checkOutput("abort_zero", ZERO, 0);
      checkOutput("abort_carry", CARRY, 0);
      checkOutput("abort_aaddr", Aaddr, 0);
      checkOutput("abort_daddr", Daddr, 0);
      checkOutput("abort_ddata", Ddata, 0);
      RST = 1'b0;
      repeat (4) @(negedge CLK);
      checkOutput("abort_r2", rf[2], 4);

      // Randomized instruction stream
      for (int n = 0; n < 40; n++) begin
         op = int'($urandom_range(0, 7));
         d = int'($urandom_range(0, 3));
         a = int'($urandom_range(0, 3));
         b = int'($urandom_range(0, 3));
         im = int'($urandom_range(0, 15));
         applyStimulus(op, d, a, b, im, ($urandom_range(0, 1) == 1), 0);
      end
      bus.INST_VALID = 1'b0;
      waitDrain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_seq_ctrl.md
Name: regfile_seq_ctrl

Overview:
- Multi-cycle instruction sequencer that drives the 4x4 register file's read ports (Aaddr/Baddr) and write port (WR/Daddr/Ddata).
- Accepts one register-to-register instruction at a time over a valid/ready handshake.
- Reads operands, computes a 4-bit result in an internal ALU, writes the result back and pulses DONE.
- Sits between the upstream instruction source (test FSM or switches) and the register file.

Parameters:
- DATA_W, 4, data width; matches the register file word width.
- ADDR_W, 2, register address width (4 registers).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- INST_VALID  in  1  instruction present on OPCODE/DST/SRCA/SRCB/IMM.
- INST_READY  out  1  controller can accept an instruction.
- OPCODE  in  3  operation, encoding below.
- DST  in  ADDR_W  destination register.
- SRCA  in  ADDR_W  operand A register.
- SRCB  in  ADDR_W  operand B register.
- IMM  in  DATA_W  immediate for LDI.
- Aaddr  out  ADDR_W  register file read port A address.
- Baddr  out  ADDR_W  register file read port B address.
- Adata  in  DATA_W  register file read data A (combinational from Aaddr).
- Bdata  in  DATA_W  register file read data B (combinational from Baddr).
- WR  out  1  register file write enable.
- Daddr  out  ADDR_W  register file write address.
- Ddata  out  DATA_W  register file write data.
- DONE  out  1  one-cycle pulse when an instruction retires.
- BUSY  out  1  high in any state other than IDLE.
- ZERO  out  1  last written result was 0.
- CARRY  out  1  ADD carry-out or SUB borrow of the last written result.

Behaviour:
- Opcodes: 000 NOP, 001 LDI (IMM), 010 MOV (A), 011 ADD (A+B), 100 SUB (A-B), 101 AND, 110 OR, 111 XOR.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE. No other transitions except reset.
- IDLE:
  - INST_READY=1.
  - On INST_VALID=1 at a rising edge: latch opcode/dst/srca/srcb/imm; go to READ.
  - Otherwise stay in IDLE.
- READ:
  - Aaddr/Baddr are driven from the latched srca/srcb, held from the accept edge until the next accept.
  - At the end of READ, capture Adata/Bdata into operand registers; go to EXEC.
- EXEC:
  - Compute the result into a DATA_W result register.
  - Compute carry:
    - ADD: carry = bit DATA_W of the (DATA_W+1)-bit sum.
    - SUB: carry = 1 iff A<B unsigned; the result wraps mod 2^DATA_W.
    - All other ops: carry = 0.
  - Go to WB.
- WB:
  - WR=1 if opcode != NOP, else WR=0. Daddr=latched dst; Ddata=result register.
  - The register file captures the write on the edge ending WB.
  - DONE=1 for this cycle only.
  - ZERO/CARRY update at the edge ending WB, only when WR=1; NOP leaves the flags unchanged.
  - Go to IDLE.
- Latency: accept edge to write edge is 3 cycles. Throughput is 1 instruction per 4 cycles, minimum.
- INST_READY=0 in READ/EXEC/WB. INST_VALID is ignored there; the source must hold its instruction until the handshake completes.
- Read-after-write: the next instruction's READ occurs at least 2 cycles after the WB write edge, so it sees the updated register. No forwarding is needed.
- Same-register operands (SRCA=SRCB=DST) are legal; operands are captured before writeback.
- LDI and MOV also pass through READ/EXEC; the operand reads are harmless.
- Reset (RST=1 at any rising edge, including mid-instruction):
  - Next state IDLE; any in-flight instruction is discarded with no write.
  - WR=0, DONE=0, BUSY=0, INST_READY=1 after the edge.
  - Aaddr=Baddr=Daddr=0, Ddata=0, ZERO=0, CARRY=0.
  - RST has priority over INST_VALID.
- WR, DONE, INST_READY and BUSY decode from state. They are never high in the same cycle as RST-induced IDLE entry except INST_READY.

Decomposition:
- Shared package/header:
  - opcode constants OP_NOP..OP_XOR;
  - FSM state encoding ST_IDLE=00, ST_READ=01, ST_EXEC=10, ST_WB=11;
  - DATA_W/ADDR_W defaults.
- One sub-module: seq_alu. Combinational; inputs op, a, b, imm; outputs result and carry. The FSM and latches stay in regfile_seq_ctrl.
- The bench instantiates regfile_seq_ctrl together with the register file.

Test Plan:
- Reset then LDI R1,#5; LDI R2,#3; ADD R3,R1,R2 -> R3=8, CARRY=0, ZERO=0. WR is high exactly 3 cycles after each accept; DONE pulses once per instruction.
- LDI R0,#9; LDI R1,#9; ADD R2,R0,R1 -> R2=2, CARRY=1. Then SUB R3,R0,R1 -> R3=0, ZERO=1, CARRY=0.
- SUB with R0=2, R1=5 -> result 13 (4'hD), CARRY=1 (borrow). Then AND/OR/XOR on 4'hC and 4'hA -> 8, E, 6.
- Hold INST_VALID high continuously with 4 queued instructions -> accept only when INST_READY=1, one per 4 cycles. The back-to-back dependent ADD R1,R1,R1 from R1=1 yields 2, 4, 8.
- Assert RST during EXEC of LDI R2,#7 (R2 previously 4) -> no WR pulse, R2 stays 4, DONE stays 0. The next cycle shows INST_READY=1, BUSY=0.
- NOP after a ZERO=1 result -> WR stays 0, DONE pulses, ZERO/CARRY unchanged, no register changes.
